// File: rtl/rv32i_inst_pkg.sv
// RV32I instruction constants and helpers shared by the fetch front end.
//
// Contents:
//   INST_NOP  - canonical NOP (addi x0, x0, 0) used for reset and pipeline bubbles
//   PC_STEP   - sequential PC increment
//   pc_sel_e  - next-PC source, ordered by priority
//   pc_select - priority decode of jump/hold into a pc_sel_e
//   word_align- force the two low address bits to zero
//   sat_inc   - saturating 32-bit increment for event counters
package rv32i_inst_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    PcJump = 2'd0,
    PcHold = 2'd1,
    PcSeq  = 2'd2
  } pc_sel_e;

  // IF/ID pipeline register contents.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{instr: INST_NOP, addr: 32'h0, valid: 1'b0};

  // A redirect always beats a stall so the stall cannot swallow it.
  function automatic pc_sel_e pc_select(input logic hold_en, input logic jump_en);
    if (jump_en) begin
      return PcJump;
    end else if (hold_en) begin
      return PcHold;
    end else begin
      return PcSeq;
    end
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == CNT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with jump > hold > sequential next-PC priority.
//
// Parameters:
//   RESET_PC  - PC after reset, must be word aligned
// Ports:
//   clk       - core clock
//   rst_n     - asynchronous active-low reset
//   hold_en   - keep the current PC
//   jump_en   - load the word-aligned jump_addr
//   jump_addr - redirect target, low two bits ignored
//   pc        - current PC
module pc_reg
  import rv32i_inst_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_en,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  pc_sel_e     pc_sel;

  assign pc_sel = pc_select(hold_en, jump_en);

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PcJump:  pc_d = word_align(jump_addr);
      PcHold:  pc_d = pc_q;
      // Natural 32-bit overflow gives the FFFF_FFFC -> 0 wrap.
      PcSeq:   pc_d = pc_q + PC_STEP;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end and IF/ID pipeline register feeding the instruction decoder.
// The PC drives the instruction ROM directly; the returned word and its PC are
// captured into IF/ID each non-held cycle. A jump redirects the PC and flushes
// IF/ID to a NOP bubble, overriding any hold in the same cycle.
//
// Build option: define IF_PERF_CNT_EN to add the fetch/bubble event counters.
//
// Parameters:
//   RESET_PC          - PC after reset, must be word aligned
// Ports:
//   clk               - core clock
//   rst_n             - asynchronous active-low reset
//   hold_en           - stall: freeze PC and IF/ID
//   jump_en           - redirect from EX: load jump_addr, flush IF/ID
//   jump_addr         - redirect target, low two bits ignored
//   rom_addr          - current PC to the instruction ROM
//   rom_rdata         - instruction at rom_addr, same cycle
//   instr_if_id       - registered instruction
//   instr_addr_if_id  - registered PC of instr_if_id
//   valid_if_id       - instr_if_id is a real fetched instruction
//   fetch_cnt         - (IF_PERF_CNT_EN) saturating count of valid captures
//   bubble_cnt        - (IF_PERF_CNT_EN) saturating count of flushes
module if_id_stage
  import rv32i_inst_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_en,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata,
  output logic [31:0] instr_if_id,
  output logic [31:0] instr_addr_if_id,
`ifdef IF_PERF_CNT_EN
  output logic        valid_if_id,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`else
  output logic        valid_if_id
`endif
);

  logic [31:0] pc;
  pc_sel_e     stage_sel;
  if_id_t      if_id_q;
  if_id_t      if_id_d;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold_en   (hold_en),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .pc        (pc)
  );

  // Purely from the PC register so no input-to-ROM combinational path exists.
  assign rom_addr = pc;

  assign stage_sel = pc_select(hold_en, jump_en);

  always_comb begin
    if_id_d = if_id_q;
    unique case (stage_sel)
      PcJump:  if_id_d = IF_ID_RESET;
      PcHold:  if_id_d = if_id_q;
      PcSeq:   if_id_d = '{instr: rom_rdata, addr: pc, valid: 1'b1};
      default: if_id_d = if_id_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q <= IF_ID_RESET;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign instr_if_id      = if_id_q.instr;
  assign instr_addr_if_id = if_id_q.addr;
  assign valid_if_id      = if_id_q.valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] fetch_cnt_d;
  logic [31:0] bubble_cnt_q;
  logic [31:0] bubble_cnt_d;

  // Counters follow the same decode as IF/ID: they freeze while held.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    unique case (stage_sel)
      PcJump:  bubble_cnt_d = sat_inc(bubble_cnt_q);
      PcHold:  ;
      PcSeq:   fetch_cnt_d = sat_inc(fetch_cnt_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a table of per-cycle stimulus with
// hand-computed PC / IF/ID expectations, then hand-written sequences for
// the mid-cycle asynchronous reset and input-independence of rom_addr.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TAG = 32'hC0DE_0000;

  logic        clk;
  logic        rst_n;
  logic        hold_en;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata;
  logic [31:0] instr_if_id;
  logic [31:0] instr_addr_if_id;
  logic        valid_if_id;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int checks;
  int errors;

  if_id_stage #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .hold_en          (hold_en),
    .jump_en          (jump_en),
    .jump_addr        (jump_addr),
    .rom_addr         (rom_addr),
    .rom_rdata        (rom_rdata),
    .instr_if_id      (instr_if_id),
    .instr_addr_if_id (instr_addr_if_id),
`ifdef IF_PERF_CNT_EN
    .valid_if_id      (valid_if_id),
    .fetch_cnt        (fetch_cnt),
    .bubble_cnt       (bubble_cnt)
`else
    .valid_if_id      (valid_if_id)
`endif
  );

  // ROM model: each word is tagged with its own address.
  function automatic logic [31:0] tag(input logic [31:0] addr);
    return addr ^ TAG;
  endfunction

  assign rom_rdata = tag(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hold;
    logic        jump;
    logic [31:0] jaddr;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic h, input logic j, input logic [31:0] ja, input logic [31:0] pc,
                     input logic [31:0] ins, input logic [31:0] ad, input logic v);
    vec_t e;
    e.hold = h; e.jump = j; e.jaddr = ja;
    e.exp_pc = pc; e.exp_instr = ins; e.exp_addr = ad; e.exp_valid = v;
    vecs.push_back(e);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_rom_addr"}, rom_addr, 32'h0);
    check({pfx, "_instr"}, instr_if_id, NOP);
    check({pfx, "_addr"}, instr_addr_if_id, 32'h0);
    check({pfx, "_valid"}, {31'h0, valid_if_id}, 32'h0);
`ifdef IF_PERF_CNT_EN
    check({pfx, "_fetch_cnt"}, fetch_cnt, 32'h0);
    check({pfx, "_bubble_cnt"}, bubble_cnt, 32'h0);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    hold_en = 1'b0;
    jump_en = 1'b0;
    jump_addr = 32'h0;

    // Expected state after each cycle's posedge, starting from pc=0.
    add(0, 0, 32'h0,         32'h4,         tag(32'h0),     32'h0,         1);
    add(0, 0, 32'h0,         32'h8,         tag(32'h4),     32'h4,         1);
    add(1, 0, 32'h0,         32'h8,         tag(32'h4),     32'h4,         1);
    add(1, 0, 32'h0,         32'h8,         tag(32'h4),     32'h4,         1);
    add(1, 0, 32'h0,         32'h8,         tag(32'h4),     32'h4,         1);
    add(0, 0, 32'h0,         32'hC,         tag(32'h8),     32'h8,         1);
    add(0, 0, 32'h0,         32'h10,        tag(32'hC),     32'hC,         1);
    add(0, 1, 32'h103,       32'h100,       NOP,            32'h0,         0);
    add(0, 0, 32'h0,         32'h104,       tag(32'h100),   32'h100,       1);
    add(1, 1, 32'h40,        32'h40,        NOP,            32'h0,         0);
    add(1, 0, 32'h0,         32'h40,        NOP,            32'h0,         0);
    add(0, 0, 32'h0,         32'h44,        tag(32'h40),    32'h40,        1);
    add(0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, NOP,            32'h0,         0);
    add(0, 0, 32'h0,         32'h0,         tag(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1);
    for (int k = 0; k < 9; k++) begin
      add(0, 0, 32'h0, 32'(k * 4 + 4), tag(32'(k * 4)), 32'(k * 4), 1);
    end

    // Reset values while reset is held across an edge.
    #12;
    check_reset_state("reset");
    rst_n = 1'b1;
    // First cycle after release: still the reset NOP.
    #1;
    check("post_release_valid", {31'h0, valid_if_id}, 32'h0);

    foreach (vecs[i]) begin
      hold_en   = vecs[i].hold;
      jump_en   = vecs[i].jump;
      jump_addr = vecs[i].jaddr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_rom_addr", i), rom_addr, vecs[i].exp_pc);
      check($sformatf("vec%0d_instr", i), instr_if_id, vecs[i].exp_instr);
      check($sformatf("vec%0d_addr", i), instr_addr_if_id, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), {31'h0, valid_if_id}, {31'h0, vecs[i].exp_valid});
    end
    hold_en = 1'b0;
    jump_en = 1'b0;
    jump_addr = 32'h0;
    check("pre_async_pc", rom_addr, 32'h24);

    // Asynchronous reset between edges: state clears before the next posedge.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(posedge clk);
    #1;
    check_reset_state("async_reset_held");
    #2;
    rst_n = 1'b1;

    // Three fetches, checking rom_addr is insensitive to a mid-cycle jump request.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("refetch%0d_addr", k), instr_addr_if_id, 32'(k * 4));
    end
    jump_en = 1'b1;
    jump_addr = 32'h200;
    #1;
    check("rom_addr_no_input_path", rom_addr, 32'hC);
    @(posedge clk);
    #1;
    jump_en = 1'b0;
    check("refetch_jump_pc", rom_addr, 32'h200);
    check("refetch_jump_valid", {31'h0, valid_if_id}, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, 32'd3);
    check("bubble_cnt", bubble_cnt, 32'd1);
    hold_en = 1'b1;
    @(posedge clk);
    #1;
    hold_en = 1'b0;
    check("fetch_cnt_hold", fetch_cnt, 32'd3);
    check("bubble_cnt_hold", bubble_cnt, 32'd1);
`endif
    @(posedge clk);
    #1;
    check("refetch_target_addr", instr_addr_if_id, 32'h200);
    check("refetch_target_instr", instr_if_id, tag(32'h200));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
